// File: rtl/vx_opc_collector_pkg.sv
// Shared types and sizing helpers for the operand collector.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package vx_opc_collector_pkg;

    localparam int NUM_THREADS_D = `NUM_THREADS;
    localparam int XLEN_D        = `XLEN;
    localparam int NUM_REGS_D    = `NUM_REGS;
    localparam int ISSUE_WIS_W   = 2;
    localparam int PERF_CTR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } opc_state_t;

    // Low register-number bits that select the bank (bank count is a power of two, >= 2).
    function automatic int OPC_BANK_SEL_BITS(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Per-bank RAM address: remaining register bits concatenated with the warp index.
    function automatic int opc_bank_addr_w(input int num_regs, input int num_banks, input int wis_w);
        return $clog2(num_regs / num_banks) + wis_w;
    endfunction

    localparam int BANK_ADDR_W_D = opc_bank_addr_w(NUM_REGS_D, 4, ISSUE_WIS_W);

endpackage

// File: rtl/vx_opc_collector_unit.sv
// One collector unit: holds an instruction's warp, sources, metadata and captured operands.
// Latency: all-r0 allocation is READY next cycle; otherwise READY the cycle after the last capture.
// Backpressure: stays READY until the top frees it on output fire.
module vx_opc_unit
    import vx_opc_collector_pkg::*;
#(
    parameter int NUM_SRC_REGS = 3,
    parameter int RS_W         = 5,
    parameter int WIS_W        = 2,
    parameter int META_W       = 64,
    parameter int DATA_W       = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_alloc,
    input  logic [WIS_W-1:0]               i_wis,
    input  logic [NUM_SRC_REGS*RS_W-1:0]   i_rs,
    input  logic [META_W-1:0]              i_meta,
    input  logic [NUM_SRC_REGS-1:0]        i_grant,
    input  logic [NUM_SRC_REGS-1:0]        i_cap_vld,
    input  logic [NUM_SRC_REGS*DATA_W-1:0] i_cap_dat,
    input  logic                           i_free,
    output opc_state_t                     o_state,
    output logic [NUM_SRC_REGS-1:0]        o_req,
    output logic [WIS_W-1:0]               o_wis,
    output logic [NUM_SRC_REGS*RS_W-1:0]   o_rs,
    output logic [META_W-1:0]              o_meta,
    output logic [NUM_SRC_REGS*DATA_W-1:0] o_data
);

    opc_state_t                     r_state, w_next;
    logic [NUM_SRC_REGS-1:0]        r_captured, r_requested, w_rs_zero;
    logic [WIS_W-1:0]               r_wis;
    logic [NUM_SRC_REGS*RS_W-1:0]   r_rs;
    logic [META_W-1:0]              r_meta;
    logic [NUM_SRC_REGS*DATA_W-1:0] r_data;

    // r0 sources need no bank read: they are pre-captured as zero
    always_comb begin
        for (int s = 0; s < NUM_SRC_REGS; s++)
            w_rs_zero[s] = (i_rs[s*RS_W +: RS_W] == '0);
    end

    // Next-state: the final capture and READY land on the same edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_alloc) w_next = (&w_rs_zero) ? READY : COLLECT;
            COLLECT: if (&(r_captured | i_cap_vld)) w_next = READY;
            READY:   if (i_free) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Requested bits stop a slot re-requesting while its read is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_captured  <= '0;
            r_requested <= '0;
        end else if (i_alloc) begin
            r_captured  <= w_rs_zero;
            r_requested <= w_rs_zero;
        end else begin
            r_captured  <= r_captured | i_cap_vld;
            r_requested <= r_requested | i_grant;
        end
    end

    // Payload: latched on allocation, operand slots filled as reads return
    always_ff @(posedge clk) begin
        if (i_alloc) begin
            r_wis  <= i_wis;
            r_rs   <= i_rs;
            r_meta <= i_meta;
            r_data <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC_REGS; s++)
                if (i_cap_vld[s]) r_data[s*DATA_W +: DATA_W] <= i_cap_dat[s*DATA_W +: DATA_W];
        end
    end

    assign o_state = r_state;
    assign o_req   = (r_state == COLLECT) ? ~r_requested : '0;
    assign o_wis   = r_wis;
    assign o_rs    = r_rs;
    assign o_meta  = r_meta;
    assign o_data  = r_data;

endmodule

// File: rtl/vx_opc_collector.sv
// Multi-entry operand collector: banked GPR reads with per-bank round-robin, out-of-order dispatch.
// Latency: in fire at T -> out_valid at T+3 conflict-free (T+1 for all-r0); +1 cycle per extra bank requester.
// Backpressure: in_ready only while an OPC is IDLE; a presented output is locked and stable until out_ready.
// Build option: OPC_PERF_EN adds o_perf_stalls (cycles with a bank conflict, wrapping).
module vx_opc_collector
    import vx_opc_collector_pkg::*;
#(
    parameter int NUM_BANKS    = 4,
    parameter int NUM_OPCS     = 2,
    parameter int NUM_SRC_REGS = 3,
    parameter int NUM_THREADS  = NUM_THREADS_D,
    parameter int XLEN         = XLEN_D,
    parameter int NUM_REGS     = NUM_REGS_D,
    parameter int WIS_W        = ISSUE_WIS_W,
    parameter int META_W       = 64
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       i_in_valid,
    output logic                                       o_in_ready,
    input  logic [WIS_W-1:0]                           i_in_wis,
    input  logic [NUM_SRC_REGS*$clog2(NUM_REGS)-1:0]   i_in_rs,
    input  logic [META_W-1:0]                          i_in_meta,
    input  logic                                       i_wb_valid,
    input  logic [WIS_W-1:0]                           i_wb_wis,
    input  logic [$clog2(NUM_REGS)-1:0]                i_wb_rd,
    input  logic [NUM_THREADS-1:0]                     i_wb_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]                i_wb_data,
    output logic                                       o_out_valid,
    input  logic                                       i_out_ready,
    output logic [META_W-1:0]                          o_out_meta,
    output logic [NUM_SRC_REGS*NUM_THREADS*XLEN-1:0]   o_out_data
`ifdef OPC_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]                   o_perf_stalls
`endif
);

    localparam int RS_W   = $clog2(NUM_REGS);
    localparam int BSEL_W = OPC_BANK_SEL_BITS(NUM_BANKS);
    localparam int ADDR_W = opc_bank_addr_w(NUM_REGS, NUM_BANKS, WIS_W);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NREQ   = NUM_OPCS * NUM_SRC_REGS;
    localparam int REQ_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OPC_W  = (NUM_OPCS > 1) ? $clog2(NUM_OPCS) : 1;
    localparam int DATA_W = NUM_THREADS * XLEN;
    localparam int SRC_DW = NUM_SRC_REGS * DATA_W;

    opc_state_t                   w_state   [NUM_OPCS];
    logic [NUM_SRC_REGS-1:0]      w_req     [NUM_OPCS];
    logic [NUM_SRC_REGS-1:0]      w_grant   [NUM_OPCS];
    logic [NUM_SRC_REGS-1:0]      w_cap_vld [NUM_OPCS];
    logic [NUM_SRC_REGS*RS_W-1:0] w_rs      [NUM_OPCS];
    logic [WIS_W-1:0]             w_wis     [NUM_OPCS];
    logic [META_W-1:0]            w_meta    [NUM_OPCS];
    logic [SRC_DW-1:0]            w_data    [NUM_OPCS];
    logic [SRC_DW-1:0]            w_cap_dat [NUM_OPCS];
    logic [NUM_OPCS-1:0]          w_alloc, w_free, w_ready;
    logic                         w_any_idle, w_out_fire, w_pick_vld;
    logic [OPC_W-1:0]             w_pick_idx, w_out_sel, r_out_sel, r_out_ptr;
    logic                         r_out_lock;

    logic [NREQ-1:0]              w_bank_req [NUM_BANKS];
    logic [NUM_BANKS-1:0]         w_gnt_vld, r_gnt_vld;
    logic [REQ_W-1:0]             w_gnt_idx  [NUM_BANKS];
    logic [REQ_W-1:0]             r_gnt_idx  [NUM_BANKS];
    logic [REQ_W-1:0]             r_bank_ptr [NUM_BANKS];
    logic [ADDR_W-1:0]            w_raddr    [NUM_BANKS];
    logic [DATA_W-1:0]            r_rdata    [NUM_BANKS];
    logic [XLEN-1:0]              r_mem      [NUM_BANKS][DEPTH][NUM_THREADS];

    function automatic logic [REQ_W:0] rr_pick_req(input logic [NREQ-1:0] req, input logic [REQ_W-1:0] ptr);
        logic [REQ_W:0] res;
        int idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!res[REQ_W] && req[idx]) res = {1'b1, REQ_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [OPC_W:0] rr_pick_opc(input logic [NUM_OPCS-1:0] req, input logic [OPC_W-1:0] ptr);
        logic [OPC_W:0] res;
        int idx;
        res = '0;
        for (int k = 0; k < NUM_OPCS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_OPCS) idx = idx - NUM_OPCS;
            if (!res[OPC_W] && req[idx]) res = {1'b1, OPC_W'(idx)};
        end
        return res;
    endfunction

    for (genvar o = 0; o < NUM_OPCS; o++) begin : g_opc
        vx_opc_unit #(
            .NUM_SRC_REGS(NUM_SRC_REGS), .RS_W(RS_W), .WIS_W(WIS_W), .META_W(META_W), .DATA_W(DATA_W)
        ) u_unit (
            .clk(clk), .reset(reset),
            .i_alloc(w_alloc[o]), .i_wis(i_in_wis), .i_rs(i_in_rs), .i_meta(i_in_meta),
            .i_grant(w_grant[o]), .i_cap_vld(w_cap_vld[o]), .i_cap_dat(w_cap_dat[o]),
            .i_free(w_free[o]),
            .o_state(w_state[o]), .o_req(w_req[o]), .o_wis(w_wis[o]), .o_rs(w_rs[o]),
            .o_meta(w_meta[o]), .o_data(w_data[o])
        );
    end

    // Allocation: lowest-index IDLE unit; in_ready depends on registered state only
    always_comb begin
        w_alloc    = '0;
        w_any_idle = 1'b0;
        for (int o = 0; o < NUM_OPCS; o++) begin
            if (w_state[o] == IDLE && !w_any_idle) begin
                w_alloc[o] = i_in_valid;
                w_any_idle = 1'b1;
            end
        end
    end
    assign o_in_ready = w_any_idle;

    // Per-bank request gathering, round-robin grant, read address and capture routing
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int o = 0; o < NUM_OPCS; o++)
                for (int s = 0; s < NUM_SRC_REGS; s++)
                    w_bank_req[b][o*NUM_SRC_REGS+s] = w_req[o][s] && (w_rs[o][s*RS_W +: BSEL_W] == BSEL_W'(b));
            {w_gnt_vld[b], w_gnt_idx[b]} = rr_pick_req(w_bank_req[b], r_bank_ptr[b]);
            w_raddr[b] = '0;
        end
        for (int o = 0; o < NUM_OPCS; o++) begin
            w_grant[o]   = '0;
            w_cap_vld[o] = '0;
            w_cap_dat[o] = '0;
            for (int s = 0; s < NUM_SRC_REGS; s++) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (w_gnt_vld[b] && w_gnt_idx[b] == REQ_W'(o*NUM_SRC_REGS+s)) begin
                        w_grant[o][s] = 1'b1;
                        w_raddr[b]    = {w_rs[o][s*RS_W+BSEL_W +: RS_W-BSEL_W], w_wis[o]};
                    end
                    if (r_gnt_vld[b] && r_gnt_idx[b] == REQ_W'(o*NUM_SRC_REGS+s)) begin
                        w_cap_vld[o][s] = 1'b1;
                        w_cap_dat[o][s*DATA_W +: DATA_W] = r_rdata[b];
                    end
                end
            end
        end
    end

    // Grant pipeline and per-bank pointers; pointer moves to one past the grantee
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            r_gnt_idx[b] <= w_gnt_idx[b];
            if (reset) begin
                r_gnt_vld[b]  <= 1'b0;
                r_bank_ptr[b] <= '0;
            end else begin
                r_gnt_vld[b] <= w_gnt_vld[b];
                if (w_gnt_vld[b])
                    r_bank_ptr[b] <= (w_gnt_idx[b] == REQ_W'(NREQ-1)) ? '0 : w_gnt_idx[b] + 1'b1;
            end
        end
    end

    // Banked GPR: registered read (old data on same-address write), per-lane write enables, never cleared
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            for (int l = 0; l < NUM_THREADS; l++)
                r_rdata[b][l*XLEN +: XLEN] <= r_mem[b][w_raddr[b]][l];
        if (i_wb_valid)
            for (int l = 0; l < NUM_THREADS; l++)
                if (i_wb_tmask[l])
                    r_mem[i_wb_rd[BSEL_W-1:0]][{i_wb_rd[RS_W-1:BSEL_W], i_wb_wis}][l] <= i_wb_data[l*XLEN +: XLEN];
    end

    // Output select: round-robin among READY units, held once presented until fire
    always_comb begin
        for (int o = 0; o < NUM_OPCS; o++) w_ready[o] = (w_state[o] == READY);
        {w_pick_vld, w_pick_idx} = rr_pick_opc(w_ready, r_out_ptr);
        w_out_sel   = r_out_lock ? r_out_sel : w_pick_idx;
        o_out_valid = r_out_lock | w_pick_vld;
        w_out_fire  = o_out_valid & i_out_ready;
        for (int o = 0; o < NUM_OPCS; o++) w_free[o] = w_out_fire && (w_out_sel == OPC_W'(o));
        o_out_meta = w_meta[w_out_sel];
        o_out_data = w_data[w_out_sel];
    end

    // Output lock and pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_lock <= 1'b0;
            r_out_sel  <= '0;
            r_out_ptr  <= '0;
        end else if (w_out_fire) begin
            r_out_lock <= 1'b0;
            r_out_ptr  <= (w_out_sel == OPC_W'(NUM_OPCS-1)) ? '0 : w_out_sel + 1'b1;
        end else if (o_out_valid) begin
            r_out_lock <= 1'b1;
            r_out_sel  <= w_out_sel;
        end
    end

`ifdef OPC_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;
    logic                     w_conflict;

    // A cycle counts as a stall when any bank sees more than one requester
    always_comb begin
        w_conflict = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++)
            if ($countones(w_bank_req[b]) > 1) w_conflict = 1'b1;
    end

    // Free-running wrapping stall counter
    always_ff @(posedge clk) begin
        if (reset)           r_perf_stalls <= '0;
        else if (w_conflict) r_perf_stalls <= r_perf_stalls + 1'b1;
    end
    assign o_perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_opc_collector.sv
// Directed bench for vx_opc_collector: latency, bank conflicts, out-of-order dispatch,
// output hold/lock, lane masks, warp addressing and mid-collection reset.
module tb_vx_opc_collector;
    import vx_opc_collector_pkg::*;

    localparam int RS_W   = 5;
    localparam int NT     = 4;
    localparam int XL     = 32;
    localparam int DATA_W = NT * XL;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  i_in_valid, o_in_ready;
    logic [1:0]            i_in_wis;
    logic [3*RS_W-1:0]     i_in_rs;
    logic [63:0]           i_in_meta;
    logic                  i_wb_valid;
    logic [1:0]            i_wb_wis;
    logic [RS_W-1:0]       i_wb_rd;
    logic [NT-1:0]         i_wb_tmask;
    logic [DATA_W-1:0]     i_wb_data;
    logic                  o_out_valid, i_out_ready;
    logic [63:0]           o_out_meta;
    logic [3*DATA_W-1:0]   o_out_data;
`ifdef OPC_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls, perf0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_opc_collector dut (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_wis(i_in_wis),
        .i_in_rs(i_in_rs), .i_in_meta(i_in_meta),
        .i_wb_valid(i_wb_valid), .i_wb_wis(i_wb_wis), .i_wb_rd(i_wb_rd),
        .i_wb_tmask(i_wb_tmask), .i_wb_data(i_wb_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_meta(o_out_meta), .o_out_data(o_out_data)
`ifdef OPC_PERF_EN
        , .o_perf_stalls(perf_stalls)
`endif
    );

    function automatic logic [DATA_W-1:0] rep(input logic [XL-1:0] v);
        return {NT{v}};
    endfunction

    function automatic logic [3*DATA_W-1:0] exp3(input logic [XL-1:0] s0, input logic [XL-1:0] s1, input logic [XL-1:0] s2);
        return {rep(s2), rep(s1), rep(s0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] wis, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2, input logic [63:0] meta);
        i_in_valid = 1'b1;
        i_in_wis   = wis;
        i_in_rs    = {r2, r1, r0};
        i_in_meta  = meta;
    endtask

    task automatic wb_write(input logic [1:0] wis, input logic [4:0] rd, input logic [NT-1:0] tmask, input logic [DATA_W-1:0] data);
        i_wb_valid = 1'b1;
        i_wb_wis   = wis;
        i_wb_rd    = rd;
        i_wb_tmask = tmask;
        i_wb_data  = data;
        tick();
        i_wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b want=1", o_in_ready); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b want=0", o_out_valid); end
`ifdef OPC_PERF_EN
        n_cmp++; if (perf_stalls !== '0) begin n_err++; $display("FAIL reset_perf got=%0d want=0", perf_stalls); end
`endif
    endtask

    task automatic preload();
        wb_write(2'd0, 5'd5,  4'hF, rep(32'h11));
        wb_write(2'd0, 5'd6,  4'hF, rep(32'h22));
        wb_write(2'd0, 5'd7,  4'hF, rep(32'h33));
        wb_write(2'd0, 5'd4,  4'hF, rep(32'h44));
        wb_write(2'd0, 5'd8,  4'hF, rep(32'h88));
        wb_write(2'd0, 5'd12, 4'hF, rep(32'hCC));
        wb_write(2'd0, 5'd1,  4'hF, rep(32'h01));
        wb_write(2'd0, 5'd2,  4'hF, rep(32'h02));
        wb_write(2'd0, 5'd3,  4'hF, rep(32'h03));
        wb_write(2'd0, 5'd9,  4'hF, rep(32'h99));
        wb_write(2'd0, 5'd9,  4'b0101, rep(32'hAA));
        wb_write(2'd1, 5'd5,  4'hF, rep(32'h55));
    endtask

    task automatic test_basic();
        i_out_ready = 1'b1;
        issue(2'd0, 5'd5, 5'd6, 5'd7, 64'hB001);
        tick(); i_in_valid = 1'b0;
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_t1_valid got=%0b want=0", o_out_valid); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_t2_valid got=%0b want=0", o_out_valid); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_t3_valid got=%0b want=1", o_out_valid); end
        n_cmp++; if (o_out_meta !== 64'hB001) begin n_err++; $display("FAIL basic_meta got=%h want=B001", o_out_meta); end
        n_cmp++; if (o_out_data !== exp3(32'h11, 32'h22, 32'h33)) begin n_err++; $display("FAIL basic_data got=%h want=%h", o_out_data, exp3(32'h11, 32'h22, 32'h33)); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_after_fire got=%0b want=0", o_out_valid); end
    endtask

    task automatic test_conflict();
`ifdef OPC_PERF_EN
        perf0 = perf_stalls;
`endif
        issue(2'd0, 5'd4, 5'd8, 5'd12, 64'hC002);
        tick(); i_in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL conflict_t4_valid got=%0b want=0", o_out_valid); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b1) begin n_err++; $display("FAIL conflict_t5_valid got=%0b want=1", o_out_valid); end
        n_cmp++; if (o_out_data !== exp3(32'h44, 32'h88, 32'hCC)) begin n_err++; $display("FAIL conflict_data got=%h want=%h", o_out_data, exp3(32'h44, 32'h88, 32'hCC)); end
        tick();
`ifdef OPC_PERF_EN
        n_cmp++; if (perf_stalls - perf0 !== PERF_CTR_BITS'(2)) begin n_err++; $display("FAIL conflict_perf_delta got=%0d want=2", perf_stalls - perf0); end
`endif
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL conflict_after_fire got=%0b want=0", o_out_valid); end
    endtask

    task automatic test_out_of_order();
        issue(2'd0, 5'd4, 5'd8, 5'd12, 64'hA003);
        tick();
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL ooo_ready_one_busy got=%0b want=1", o_in_ready); end
        issue(2'd0, 5'd1, 5'd2, 5'd3, 64'hB003);
        tick(); i_in_valid = 1'b0;
        n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL ooo_full_ready got=%0b want=0", o_in_ready); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL ooo_t3_valid got=%0b want=0", o_out_valid); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hB003) begin n_err++; $display("FAIL ooo_first got v=%0b meta=%h want v=1 meta=B003", o_out_valid, o_out_meta); end
        n_cmp++; if (o_out_data !== exp3(32'h01, 32'h02, 32'h03)) begin n_err++; $display("FAIL ooo_b_data got=%h want=%h", o_out_data, exp3(32'h01, 32'h02, 32'h03)); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hA003) begin n_err++; $display("FAIL ooo_second got v=%0b meta=%h want v=1 meta=A003", o_out_valid, o_out_meta); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL ooo_drained got=%0b want=0", o_out_valid); end
    endtask

    task automatic test_all_zero();
        issue(2'd0, 5'd0, 5'd0, 5'd0, 64'hD004);
        tick(); i_in_valid = 1'b0;
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hD004) begin n_err++; $display("FAIL zero_t1 got v=%0b meta=%h want v=1 meta=D004", o_out_valid, o_out_meta); end
        n_cmp++; if (o_out_data !== '0) begin n_err++; $display("FAIL zero_data got=%h want=0", o_out_data); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL zero_after_fire got=%0b want=0", o_out_valid); end
    endtask

    task automatic test_hold();
        logic [3*DATA_W-1:0] x_exp, y_exp;
        x_exp = {256'b0, 32'h99, 32'hAA, 32'h99, 32'hAA};
        y_exp = exp3(32'h0, 32'h0, 32'h22);
        i_out_ready = 1'b0;
        issue(2'd0, 5'd9, 5'd0, 5'd0, 64'hE005);
        tick();
        issue(2'd0, 5'd0, 5'd0, 5'd6, 64'hF005);
        tick(); i_in_valid = 1'b0;
        n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_full_ready got=%0b want=0", o_in_ready); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hE005) begin n_err++; $display("FAIL hold_t3 got v=%0b meta=%h want v=1 meta=E005", o_out_valid, o_out_meta); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hE005) begin n_err++; $display("FAIL hold_stable_meta cyc=%0d got v=%0b meta=%h want v=1 meta=E005", c, o_out_valid, o_out_meta); end
            n_cmp++; if (o_out_data !== x_exp) begin n_err++; $display("FAIL hold_stable_data cyc=%0d got=%h want=%h", c, o_out_data, x_exp); end
            n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready cyc=%0d got=%0b want=0", c, o_in_ready); end
        end
        i_out_ready = 1'b1;
        tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_meta !== 64'hF005) begin n_err++; $display("FAIL hold_second got v=%0b meta=%h want v=1 meta=F005", o_out_valid, o_out_meta); end
        n_cmp++; if (o_out_data !== y_exp) begin n_err++; $display("FAIL hold_second_data got=%h want=%h", o_out_data, y_exp); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL hold_freed_ready got=%0b want=1", o_in_ready); end
        tick();
        n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL hold_drained got=%0b want=0", o_out_valid); end
    endtask

    task automatic test_warp();
        issue(2'd1, 5'd5, 5'd0, 5'd0, 64'h1006);
        tick(); i_in_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== exp3(32'h55, 32'h0, 32'h0)) begin n_err++; $display("FAIL warp1_data got v=%0b data=%h want v=1 data=%h", o_out_valid, o_out_data, exp3(32'h55, 32'h0, 32'h0)); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(2'd0, 5'd4, 5'd8, 5'd12, 64'h2007);
        tick(); i_in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%0b want=1", o_in_ready); end
`ifdef OPC_PERF_EN
        n_cmp++; if (perf_stalls !== '0) begin n_err++; $display("FAIL midrst_perf got=%0d want=0", perf_stalls); end
`endif
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_output cyc=%0d got=%0b want=0", c, o_out_valid); end
            tick();
        end
        issue(2'd0, 5'd5, 5'd6, 5'd7, 64'h3007);
        tick(); i_in_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== exp3(32'h11, 32'h22, 32'h33)) begin n_err++; $display("FAIL midrst_gpr_kept got v=%0b data=%h want v=1 data=%h", o_out_valid, o_out_data, exp3(32'h11, 32'h22, 32'h33)); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        i_in_valid = 1'b0; i_in_wis = '0; i_in_rs = '0; i_in_meta = '0;
        i_wb_valid = 1'b0; i_wb_wis = '0; i_wb_rd = '0; i_wb_tmask = '0; i_wb_data = '0;
        i_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        preload();
        test_basic();
        test_conflict();
        test_out_of_order();
        test_all_zero();
        test_hold();
        test_warp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
